// File: rtl/puf_pkg.sv
// Shared types and default constants for the PUF response controller.
// Sizing parameters of puf_resp_ctrl default to the DEF_* values below.
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    COUNT,
    SETTLE,
    COMPARE,
    FINISH
  } puf_state_e;

  localparam int DEF_CNT_W         = 128;
  localparam int DEF_RESP_BITS     = 16;
  localparam int DEF_WINDOW_CYCLES = 1024;
  localparam int DEF_SETTLE_CYCLES = 4;

  // Oscillator counters are held in reset this long before every bit.
  localparam int CLEAR_CYCLES      = 2;

endpackage

// File: rtl/puf_phase_timer.sv
// Load-and-count-down phase timer.
// expire is high for exactly one cycle: the last cycle of a loaded duration.
module puf_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // A load of N gives N cycles, the last of which flags expire.
  assign expire = (cnt == W'(1));

endmodule

// File: rtl/puf_resp_ctrl.sv
// Ring-oscillator PUF response sequencer: clears, runs and compares one
// oscillator pair per response bit, accumulating the response and tie count.
//
// state   | meaning
// IDLE    | counters held in reset, waiting for start
// CLEAR   | counters held in reset before the counting window
// COUNT   | both oscillator counters running
// SETTLE  | counters stopped, waiting for values to be stable
// COMPARE | count1 vs count2 written into response[chal_idx]
// FINISH  | done pulse, then back to IDLE
module puf_resp_ctrl
  import puf_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int RESP_BITS     = DEF_RESP_BITS,
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [CNT_W-1:0]               count1,
  input  logic [CNT_W-1:0]               count2,
  output logic                           ro_reset,
  output logic                           ro_enable,
  output logic [$clog2(RESP_BITS)-1:0]   chal_idx,
  output logic                           busy,
  output logic                           done,
  output logic [RESP_BITS-1:0]           response,
  output logic [$clog2(RESP_BITS):0]     tie_cnt
);

  localparam int IDX_W  = $clog2(RESP_BITS);
  localparam int TIE_W  = IDX_W + 1;
  localparam int MAX_WS = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int MAX_LN = (MAX_WS > CLEAR_CYCLES) ? MAX_WS : CLEAR_CYCLES;
  localparam int TW     = $clog2(MAX_LN + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESP_BITS - 1);

  puf_state_e    state;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_expire;

  puf_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  // The timer is loaded on the same edge the FSM enters a timed phase.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      IDLE: begin
        if (start) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(CLEAR_CYCLES);
        end
      end
      CLEAR: begin
        if (tmr_expire) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(WINDOW_CYCLES);
        end
      end
      COUNT: begin
        if (tmr_expire) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(SETTLE_CYCLES);
        end
      end
      COMPARE: begin
        if (chal_idx != LAST_IDX) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(CLEAR_CYCLES);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ro_reset  <= 1'b1;
      ro_enable <= 1'b0;
      chal_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      response  <= '0;
      tie_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          ro_reset  <= 1'b1;
          ro_enable <= 1'b0;
          if (start) begin
            state    <= CLEAR;
            busy     <= 1'b1;
            chal_idx <= '0;
            response <= '0;
            tie_cnt  <= '0;
          end
        end
        CLEAR: begin
          if (tmr_expire) begin
            state     <= COUNT;
            ro_reset  <= 1'b0;
            ro_enable <= 1'b1;
          end
        end
        COUNT: begin
          if (tmr_expire) begin
            state     <= SETTLE;
            ro_enable <= 1'b0;
          end
        end
        SETTLE: begin
          if (tmr_expire) begin
            state <= COMPARE;
          end
        end
        COMPARE: begin
          // Ties fall out as 0 from the strict greater-than compare.
          response[chal_idx] <= (count1 > count2);
          if (count1 == count2) begin
            tie_cnt <= tie_cnt + TIE_W'(1);
          end
          ro_reset <= 1'b1;
          if (chal_idx == LAST_IDX) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            state    <= CLEAR;
            chal_idx <= chal_idx + IDX_W'(1);
          end
        end
        FINISH: begin
          state    <= IDLE;
          busy     <= 1'b0;
          ro_reset <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_resp_ctrl.sv
// Bench for puf_resp_ctrl: a cycle-timeline model checked every cycle,
// plus directed runs with literal expected responses and latency.
module tb_puf_resp_ctrl;

  localparam int CW = 128;
  localparam int RB = 4;
  localparam int WC = 8;
  localparam int SC = 2;
  localparam int P    = 3 + WC + SC;
  localparam int LAST = RB * P + 1;

  localparam int PH_IDLE = 0;
  localparam int PH_CLR  = 1;
  localparam int PH_CNT  = 2;
  localparam int PH_SET  = 3;
  localparam int PH_CMP  = 4;
  localparam int PH_FIN  = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] count1 = '0;
  logic [CW-1:0] count2 = '0;
  logic          ro_reset, ro_enable, busy, done;
  logic [1:0]    chal_idx;
  logic [RB-1:0] response;
  logic [2:0]    tie_cnt;

  puf_resp_ctrl #(
    .CNT_W(CW), .RESP_BITS(RB), .WINDOW_CYCLES(WC), .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .count1(count1), .count2(count2),
    .ro_reset(ro_reset), .ro_enable(ro_enable), .chal_idx(chal_idx),
    .busy(busy), .done(done), .response(response), .tie_cnt(tie_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [CW-1:0] c1_tab [RB];
  logic [CW-1:0] c2_tab [RB];

  // Model: a run is a timeline of cycles 1..LAST counted from the accept edge.
  bit            m_active = 1'b0;
  int            m_t = 0;
  logic [RB-1:0] m_resp = '0;
  int            m_tie = 0;

  function automatic int cur_phase();
    int o;
    if (!m_active) return PH_IDLE;
    if (m_t == LAST) return PH_FIN;
    o = (m_t - 1) % P;
    if (o < 2) return PH_CLR;
    if (o < 2 + WC) return PH_CNT;
    if (o < 2 + WC + SC) return PH_SET;
    return PH_CMP;
  endfunction

  function automatic int cur_bit();
    if (!m_active || m_t == LAST) return 0;
    return (m_t - 1) / P;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_active = 1'b0;
      m_t      = 0;
      m_resp   = '0;
      m_tie    = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_t      = 1;
        m_resp   = '0;
        m_tie    = 0;
      end
    end else begin
      if (cur_phase() == PH_CMP) begin
        m_resp[cur_bit()] = (c1_tab[cur_bit()] > c2_tab[cur_bit()]);
        if (c1_tab[cur_bit()] == c2_tab[cur_bit()]) m_tie++;
      end
      if (m_t == LAST) m_active = 1'b0;
      else m_t++;
    end
  end

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int ph;
    if (chk_en) begin
      ph = cur_phase();
      chk("busy", CW'(busy), CW'(m_active));
      chk("done", CW'(done), CW'(ph == PH_FIN));
      chk("ro_enable", CW'(ro_enable), CW'(ph == PH_CNT));
      if (ph == PH_IDLE || ph == PH_CLR) chk("ro_reset", CW'(ro_reset), CW'(1));
      else if (ph == PH_CNT || ph == PH_SET) chk("ro_reset", CW'(ro_reset), CW'(0));
      if (ph >= PH_CLR && ph <= PH_CMP) chk("chal_idx", CW'(chal_idx), CW'(cur_bit()));
      chk("response", CW'(response), CW'(m_resp));
      chk("tie_cnt", CW'(tie_cnt), CW'(m_tie));
    end
  end

  // Oscillator stand-in: present the counts of the bit being measured.
  initial begin
    forever begin
      @(negedge clk);
      count1 = c1_tab[cur_bit()];
      count2 = c2_tab[cur_bit()];
    end
  end

  task automatic set_tabs(input logic [CW-1:0] a0, a1, a2, a3,
                          input logic [CW-1:0] b0, b1, b2, b3);
    c1_tab[0] = a0; c1_tab[1] = a1; c1_tab[2] = a2; c1_tab[3] = a3;
    c2_tab[0] = b0; c2_tab[1] = b1; c2_tab[2] = b2; c2_tab[3] = b3;
  endtask

  // Called at a negedge with the DUT idle. busy_at > 0 pulses start mid-run.
  task automatic run_resp(input string nm, input logic [RB-1:0] exp_resp,
                          input int exp_tie, input int busy_at);
    int cyc;
    int extra;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = (cyc == busy_at);
    end
    start = 1'b0;
    chk({nm, "_latency"}, CW'(cyc), CW'(RB * (3 + WC + SC) + 1));
    chk({nm, "_response"}, CW'(response), CW'(exp_resp));
    chk({nm, "_tie_cnt"}, CW'(tie_cnt), CW'(exp_tie));
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk({nm, "_extra_done"}, CW'(extra), CW'(0));
    chk({nm, "_idle_hold"}, CW'(response), CW'(exp_resp));
  endtask

  initial begin
    logic [CW-1:0] ones;
    logic [CW-1:0] big;
    bit found;
    ones = '1;
    set_tabs(100, 100, 100, 100, 50, 50, 50, 50);

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ro_reset", CW'(ro_reset), CW'(1));
    chk("rst_ro_enable", CW'(ro_enable), CW'(0));
    chk("rst_chal_idx", CW'(chal_idx), CW'(0));
    chk("rst_busy", CW'(busy), CW'(0));
    chk("rst_done", CW'(done), CW'(0));
    chk("rst_response", CW'(response), CW'(0));
    chk("rst_tie_cnt", CW'(tie_cnt), CW'(0));
    chk_en = 1'b1;
    reset = 1'b0;
    @(negedge clk);

    run_resp("all_gt", 4'b1111, 0, 0);

    set_tabs(100, 10, 100, 10, 50, 20, 50, 20);
    run_resp("bits02", 4'b0101, 0, 0);

    set_tabs(77, 77, 77, 77, 77, 77, 77, 77);
    run_resp("all_tie", 4'b0000, 4, 0);

    // Reset in the middle of bit 2's counting window.
    set_tabs(100, 100, 100, 100, 50, 50, 50, 50);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (cur_phase() == PH_CNT && cur_bit() == 2) found = 1'b1;
    end
    chk("reach_count_bit2", CW'(found), CW'(1));
    chk("pre_reset_response", CW'(response), CW'(4'b0011));
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", CW'(busy), CW'(0));
    chk("midrst_ro_reset", CW'(ro_reset), CW'(1));
    chk("midrst_ro_enable", CW'(ro_enable), CW'(0));
    chk("midrst_response", CW'(response), CW'(0));
    reset = 1'b0;
    @(negedge clk);
    run_resp("after_rst", 4'b1111, 0, 0);

    set_tabs(5, 9, 3, 77, 5, 2, 4, 77);
    run_resp("start_busy", 4'b0010, 2, 20);

    big = CW'(1) << 100;
    set_tabs(ones, ones - 1, 5, CW'(1) << 127, ones - 1, ones, big, ones >> 1);
    run_resp("saturate", 4'b1001, 0, 0);

    // Reset and start on the same edge: reset wins.
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", CW'(busy), CW'(0));
    chk("rst_start_response", CW'(response), CW'(0));
    repeat (3) @(negedge clk);
    chk("rst_start_still_idle", CW'(busy), CW'(0));

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/puf_resp_ctrl.md
PUF_RESP_CTRL -- requirements
Module: puf_resp_ctrl

Interface
REQ-001 SHALL have parameters: CNT_W, default 128, width of each ring-oscillator count; RESP_BITS, default 16, response length in bits; WINDOW_CYCLES, default 1024, clk cycles of counting per bit; SETTLE_CYCLES, default 4, clk cycles waited after counting stops.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to generate a response.
- count1  in  CNT_W  counter value from ring oscillator 1.
- count2  in  CNT_W  counter value from ring oscillator 2.
- ro_reset  out  1  clears both oscillator counters.
- ro_enable  out  1  lets both oscillator counters run.
- chal_idx  out  $clog2(RESP_BITS)  selects the oscillator pair for the current bit.
- busy  out  1  generation in progress.
- done  out  1  one-cycle pulse when the response is complete.
- response  out  RESP_BITS  generated response.
- tie_cnt  out  $clog2(RESP_BITS)+1  number of bits where count1 == count2.

Function
REQ-003 SHALL implement the FSM states IDLE, CLEAR, COUNT, SETTLE, COMPARE and FINISH.
REQ-004 IDLE: ro_reset=1, ro_enable=0, busy=0; start=1 -> CLEAR, with chal_idx=0, response=0 and tie_cnt=0 loaded on the same edge.
REQ-005 CLEAR: lasts exactly 2 cycles; ro_reset=1, ro_enable=0, busy=1; then -> COUNT.
REQ-006 COUNT: lasts exactly WINDOW_CYCLES cycles; ro_reset=0, ro_enable=1; then -> SETTLE.
REQ-007 SETTLE: lasts exactly SETTLE_CYCLES cycles; ro_reset=0, ro_enable=0; counts must be stable by its end.
REQ-008 COMPARE: lasts 1 cycle.
- response[chal_idx] <= (count1 > count2), as an unsigned CNT_W-bit compare.
- If count1 == count2: write bit 0 and increment tie_cnt.
REQ-009 COMPARE exit:
- chal_idx == RESP_BITS-1 -> FINISH.
- Otherwise chal_idx increments and the FSM goes -> CLEAR.
REQ-010 FINISH: lasts 1 cycle; done=1, busy=1; then -> IDLE.
REQ-011 start SHALL be ignored in every state except IDLE.
REQ-012 response and tie_cnt SHALL hold their values in IDLE until the next accepted start.
REQ-013 Saturated counts (all ones) SHALL be compared like any other value; no special case.
REQ-014 Per-response latency SHALL be RESP_BITS*(3+WINDOW_CYCLES+SETTLE_CYCLES)+1 cycles from the start-accept edge to done.
REQ-015 chal_idx SHALL stay constant from CLEAR through COMPARE of a given bit.

Reset
REQ-016 When reset=1 at a clk edge, SHALL enter IDLE from any state, including mid-COUNT.
REQ-017 Reset values SHALL be: ro_reset=1, ro_enable=0, chal_idx=0, busy=0, done=0, response=0, tie_cnt=0.
REQ-018 If reset and start are both high on the same edge, reset SHALL win and start is dropped.

Structure
REQ-019 The state enum and the default parameter constants SHALL live in the shared package puf_pkg.
REQ-020 The CLEAR/COUNT/SETTLE phase length SHALL be timed by one sub-module, puf_phase_timer: a load-and-count-down counter with a one-cycle expiry pulse.
REQ-021 Outputs SHALL be registered; there SHALL be no combinational path from count1/count2 to any output.

Verification
REQ-022 The bench SHALL use WINDOW_CYCLES=8, SETTLE_CYCLES=2 and RESP_BITS=4, and SHALL cover:
- Model count1=100, count2=50 for every bit; pulse start -> response=4'b1111, tie_cnt=0, done exactly 53 cycles after the start edge.
- Model count1>count2 for bits 0 and 2 only -> response=4'b0101.
- count1=count2=77 for every bit -> response=4'b0000, tie_cnt=4.
- Assert reset during COUNT of bit 2 -> next cycle IDLE, ro_reset=1, response=0; a new start then completes normally.
- Pulse start while busy -> no restart and no change to chal_idx; single done pulse.
- count1 all ones, count2 all ones minus 1 -> bit=1 (saturation compare).
